keycode_event_queue: RTL and testbench

KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

---
 rtl/keycode_event_queue_if.sv | 25 ++
 rtl/keycode_event_queue.sv | 193 +++++++++++++++++++
 tb/tb_keycode_event_queue.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keycode_event_queue_if.sv
// Event handshake bundle between keycode_event_queue and its consumer.
// Master drives the show-ahead head event; slave returns evt_ready.
interface keycode_event_queue_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_press;
    logic       evt_repeat;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/keycode_event_queue.sv
// Keycode edge detector feeding a show-ahead press/release event FIFO.
// Define KEYCODE_AUTOREPEAT_EN to build frame_tick driven auto-repeat.
module keycode_event_queue #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic [7:0]                   keycode,
    input  logic                         frame_tick,
    keycode_event_queue_if.master        evt,
    output logic [7:0]                   held_key,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REL,
        PRESS
    } state_t;

    typedef struct packed {
        logic       rpt;
        logic       press;
        logic [7:0] code;
    } evt_t;

    state_t        state_q, state_d;
    logic [7:0]    keycode_q;
    logic [7:0]    cur_key_q, cur_key_d;
    logic [7:0]    new_key_q, new_key_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    evt_t          mem_q [FIFO_DEPTH];

    logic          push;
    evt_t          push_evt;
    logic          rpt_clr;
    logic          rpt_fire;
    logic          full;
    logic          valid;
    logic          pop;
    logic          do_push;
    logic          drop;
    evt_t          head;

    always_comb begin
        state_d   = state_q;
        cur_key_d = cur_key_q;
        new_key_d = new_key_q;
        push      = 1'b0;
        push_evt  = '0;
        rpt_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (keycode_q != cur_key_q) begin
                    new_key_d = keycode_q;
                    state_d   = (cur_key_q != 8'd0) ? REL : PRESS;
                end else if (rpt_fire) begin
                    push     = 1'b1;
                    push_evt = '{rpt: 1'b1, press: 1'b1, code: cur_key_q};
                end
            end
            REL: begin
                push      = 1'b1;
                push_evt  = '{rpt: 1'b0, press: 1'b0, code: cur_key_q};
                cur_key_d = 8'd0;
                state_d   = (new_key_q != 8'd0) ? PRESS : IDLE;
            end
            PRESS: begin
                push      = 1'b1;
                push_evt  = '{rpt: 1'b0, press: 1'b1, code: new_key_q};
                cur_key_d = new_key_q;
                rpt_clr   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            keycode_q <= 8'd0;
            cur_key_q <= 8'd0;
            new_key_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            keycode_q <= keycode;
            cur_key_q <= cur_key_d;
            new_key_q <= new_key_d;
        end
    end

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                        : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RW-1:0] rpt_nxt;
    logic [RW-1:0] rpt_lim;
    logic          rpt_first_q, rpt_first_d;
    logic          rpt_arm;

    // Counting only while the held key is stable in IDLE lets a change win.
    assign rpt_arm  = (state_q == IDLE) && (cur_key_q != 8'd0)
                   && (keycode_q == cur_key_q) && frame_tick;
    assign rpt_nxt  = rpt_cnt_q + RW'(1);
    assign rpt_lim  = rpt_first_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    assign rpt_fire = rpt_arm && (rpt_nxt == rpt_lim);

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        if (rpt_clr) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_arm) begin
            rpt_cnt_d   = rpt_nxt;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign evt.evt_repeat = valid & head.rpt;
`else
    logic unused_rpt;

    assign rpt_fire       = 1'b0;
    assign unused_rpt     = head.rpt ^ rpt_clr ^ frame_tick;
    assign evt.evt_repeat = 1'b0;
`endif

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign valid   = (count_q != '0);
    assign pop     = valid & evt.evt_ready;
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    // Pointers are AW bits wide, so the power-of-two depth wraps for free.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
            overflow_q <= overflow_q | drop;
        end
    end

    assign evt.evt_valid = valid;
    assign evt.evt_code  = valid ? head.code : 8'd0;
    assign evt.evt_press = valid & head.press;
    assign held_key      = cur_key_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Self-checking bench for keycode_event_queue: directed steps plus random
// key changes checked against an event-list reference model.
module tb_keycode_event_queue;

    localparam int DEPTH = 4;
    localparam int RDLY  = 30;
    localparam int RRATE = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] keycode;
    logic       frame_tick;
    logic [7:0] held_key;
    logic       overflow;

    keycode_event_queue_if evt_if ();

    keycode_event_queue #(
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_DELAY (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .keycode       (keycode),
        .frame_tick    (frame_tick),
        .evt           (evt_if.master),
        .held_key      (held_key),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         rpt_seen = 0;
    int         pop_cyc [$];
    logic [9:0] exp_q [$];
    logic [7:0] mkey;
    bit         mdrop;
    bit         hold_pending = 0;
    logic [9:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ev(logic [7:0] c, logic p, logic r);
        return {c, p, r};
    endfunction

    function automatic logic [9:0] obs_ev();
        return {evt_if.evt_code, evt_if.evt_press, evt_if.evt_repeat};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a key change emits release(old) then press(new), zero
    // codes omitted; with no pops, events beyond DEPTH are lost.
    task automatic model_push(logic [9:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else mdrop = 1'b1;
    endtask

    task automatic set_key(logic [7:0] k);
        if (k != mkey) begin
            if (mkey != 8'd0) model_push(ev(mkey, 1'b0, 1'b0));
            if (k != 8'd0) model_push(ev(k, 1'b1, 1'b0));
            mkey = k;
        end
        keycode = k;
    endtask

    task automatic drain();
        int n;
        n = 0;
        evt_if.evt_ready = 1'b1;
        while (evt_if.evt_valid && n < 40) begin
            step(1);
            n++;
        end
        chk("drain_done", evt_if.evt_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        mkey  = 8'd0;
        mdrop = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                assert (obs_ev() === hold_val) else begin
                    failures++;
                    $error("FAIL hold_stable observed=%0h expected=%0h",
                           obs_ev(), hold_val);
                end
            end
            if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_event observed=%0h expected=none",
                           obs_ev());
                end
                if (exp_q.size() != 0) begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert (obs_ev() === e) else begin
                        failures++;
                        $error("FAIL event observed=%0h expected=%0h",
                               obs_ev(), e);
                    end
                end
                pop_cyc.push_back(cyc);
                if (evt_if.evt_repeat === 1'b1) rpt_seen++;
            end
            hold_pending = evt_if.evt_valid && !evt_if.evt_ready;
            hold_val     = obs_ev();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rpt;
        rst_n            = 1'b0;
        keycode          = 8'd0;
        frame_tick       = 1'b0;
        evt_if.evt_ready = 1'b0;
        mkey             = 8'd0;
        mdrop            = 1'b0;
        step(2);
        chk("rst_valid",  evt_if.evt_valid, 1'b0);
        chk("rst_code",   evt_if.evt_code, 8'd0);
        chk("rst_press",  evt_if.evt_press, 1'b0);
        chk("rst_repeat", evt_if.evt_repeat, 1'b0);
        chk("rst_held",   held_key, 8'd0);
        chk("rst_ovf",    overflow, 1'b0);
        rst_n = 1'b1;
        step(1);

        // Register, compare in IDLE, push in PRESS, visible next cycle.
        set_key(8'h04);
        step(2);
        chk("lat_early", evt_if.evt_valid, 1'b0);
        step(1);
        chk("lat_valid", evt_if.evt_valid, 1'b1);
        chk("lat_code",  evt_if.evt_code, 8'h04);
        chk("lat_press", evt_if.evt_press, 1'b1);
        chk("lat_rpt",   evt_if.evt_repeat, 1'b0);
        chk("lat_held",  held_key, 8'h04);
        step(3);
        chk("lat_stay",  evt_if.evt_valid, 1'b1);
        drain();

        pop_cyc.delete();
        set_key(8'h1A);
        step(6);
        chk("ab_held", held_key, 8'h1A);
        chk("ab_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2)
            chk("ab_gap", pop_cyc[1] - pop_cyc[0], 1);
        set_key(8'h00);
        step(6);
        drain();
        chk("a0_held", held_key, 8'h00);
        chk("a0_left", exp_q.size(), 0);

        evt_if.evt_ready = 1'b0;
        set_key(8'h05); step(5);
        set_key(8'h06); step(5);
        set_key(8'h07); step(5);
        set_key(8'h00); step(5);
        chk("ovf_model", mdrop, 1'b1);
        chk("ovf_set",   overflow, 1'b1);
        chk("ovf_head",  evt_if.evt_code, 8'h05);
        drain();
        chk("ovf_left",   exp_q.size(), 0);
        chk("ovf_sticky", overflow, 1'b1);

        do_reset();
        chk("ovf_clr", overflow, 1'b0);
        evt_if.evt_ready = 1'b0;
        set_key(8'h10); step(5);
        set_key(8'h11); step(5);
        set_key(8'h00); step(5);
        chk("full_ovf", overflow, 1'b0);
        keycode = 8'h20;
        mkey    = 8'h20;
        step(2);
        evt_if.evt_ready = 1'b1;
        step(1);
        evt_if.evt_ready = 1'b0;
        exp_q.push_back(ev(8'h20, 1'b1, 1'b0));
        step(3);
        chk("pp_ovf",   overflow, 1'b0);
        chk("pp_head",  evt_if.evt_code, 8'h10);
        chk("pp_press", evt_if.evt_press, 1'b0);
        drain();
        chk("pp_left", exp_q.size(), 0);

        evt_if.evt_ready = 1'b0;
        set_key(8'h00); step(5);
        set_key(8'h30); step(5);
        keycode = 8'h31;
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        chk("mid_valid", evt_if.evt_valid, 1'b0);
        chk("mid_held",  held_key, 8'h00);
        chk("mid_ovf",   overflow, 1'b0);
        mkey = 8'h31;
        exp_q.push_back(ev(8'h31, 1'b1, 1'b0));
        step(5);
        chk("post_code", evt_if.evt_code, 8'h31);
        drain();

        evt_if.evt_ready = 1'b1;
        set_key(8'h2C);
        step(6);
        rpt_seen = 0;
        exp_rpt  = 0;
        for (int i = 1; i <= 42; i++) begin
`ifdef KEYCODE_AUTOREPEAT_EN
            if (i >= RDLY && (i - RDLY) % RRATE == 0) begin
                exp_q.push_back(ev(8'h2C, 1'b1, 1'b1));
                exp_rpt++;
            end
`endif
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(2);
        end
        step(4);
        drain();
        chk("rpt_count", rpt_seen, exp_rpt);
        chk("rpt_left",  exp_q.size(), 0);
        chk("rpt_held",  held_key, 8'h2C);
        set_key(8'h00);
        step(6);
        drain();

        for (int it = 0; it < 20; it++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) set_key(8'h00);
            else if (r == 1) set_key(mkey);
            else set_key(8'($urandom_range(1, 255)));
            for (int c = 0; c < 8; c++) begin
                evt_if.evt_ready = 1'($urandom_range(0, 1));
                step(1);
            end
            drain();
            chk("rnd_held", held_key, mkey);
        end
        chk("rnd_left", exp_q.size(), 0);
        chk("rnd_ovf",  overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
